// File: rtl/ra_stack_ctrl_if.sv
// Call/return bus between the pipeline and the return-address stack controller.
// The pipeline side (master) issues calls/returns and observes the $ra write-back and status.
interface ra_stack_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  logic                     jal;
  logic                     jr_ra;
  logic [WIDTH-1:0]         pc_plus4;
  logic                     flag_clr;
  logic                     ra_wr_en;
  logic [WIDTH-1:0]         ra_wr_data;
  logic [WIDTH-1:0]         ra_top;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output jal, jr_ra, pc_plus4, flag_clr,
    input  ra_wr_en, ra_wr_data, ra_top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  jal, jr_ra, pc_plus4, flag_clr,
    output ra_wr_en, ra_wr_data, ra_top, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/ra_stack_ctrl.sv
// Return-address stack: circular buffer of call return addresses with a registered
// $ra write-back port and sticky overflow/underflow flags.
//
// state     | meaning
// ST_EMPTY  | count == 0, ra_top reads 0, pops underflow
// ST_ACTIVE | 1 <= count <= DEPTH-1
// ST_FULL   | count == DEPTH, next push overwrites the oldest entry
module ra_stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  ra_stack_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [CW-1:0]    cnt;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             ovf;
  logic             udf;

  logic push, repl, pop_ok, pop_bad;

  // Call+return together replaces the top entry, except on an empty stack where it is a plain push.
  always_comb begin
    push    = bus.jal && (!bus.jr_ra || state == ST_EMPTY);
    repl    = bus.jal && bus.jr_ra && state != ST_EMPTY;
    pop_ok  = !bus.jal && bus.jr_ra && state != ST_EMPTY;
    pop_bad = !bus.jal && bus.jr_ra && state == ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[top + PW'(1)] <= bus.pc_plus4;
    else if (!reset && repl)
      mem[top] <= bus.pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      top     <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (bus.flag_clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (push) begin
        top     <= top + PW'(1);
        wr_en   <= 1'b1;
        wr_data <= bus.pc_plus4;
        if (state == ST_FULL) begin
          ovf <= 1'b1;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= (cnt == CW'(DEPTH - 1)) ? ST_FULL : ST_ACTIVE;
        end
      end else if (repl) begin
        wr_en   <= 1'b1;
        wr_data <= bus.pc_plus4;
      end else if (pop_ok) begin
        top <= top - PW'(1);
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state   <= ST_EMPTY;
          wr_data <= '0;
        end else begin
          state   <= ST_ACTIVE;
          wr_en   <= 1'b1;
          wr_data <= mem[top - PW'(1)];
        end
      end else if (pop_bad) begin
        udf <= 1'b1;
      end
    end
  end

  assign bus.ra_wr_en   = wr_en;
  assign bus.ra_wr_data = wr_data;
  assign bus.ra_top     = (state == ST_EMPTY) ? '0 : mem[top];
  assign bus.count      = cnt;
  assign bus.full       = (state == ST_FULL);
  assign bus.empty      = (state == ST_EMPTY);
  assign bus.overflow   = ovf;
  assign bus.underflow  = udf;
endmodule

// File: tb/tb_ra_stack_ctrl.sv
// Bench for ra_stack_ctrl: queue-based stack model checked every cycle, directed
// scenarios with literal expectations, then randomized call/return traffic.
module tb_ra_stack_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ra_stack_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  ra_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] stk[$];
  bit          m_wr_en   = 1'b0;
  logic [31:0] m_wr_data = '0;
  bit          m_ovf     = 1'b0;
  bit          m_udf     = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit j, bit r, logic [31:0] pc, bit c, bit rs);
    if (rs) begin
      stk.delete();
      m_wr_en = 0; m_wr_data = '0; m_ovf = 0; m_udf = 0;
      return;
    end
    m_wr_en = 0;
    if (c) begin m_ovf = 0; m_udf = 0; end
    if (j && r && stk.size() > 0) begin
      stk[stk.size()-1] = pc;
      m_wr_en = 1; m_wr_data = pc;
    end else if (j) begin
      stk.push_back(pc);
      if (stk.size() > DEPTH) begin
        void'(stk.pop_front());
        m_ovf = 1;
      end
      m_wr_en = 1; m_wr_data = pc;
    end else if (r) begin
      if (stk.size() == 0) m_udf = 1;
      else begin
        void'(stk.pop_back());
        if (stk.size() == 0) m_wr_data = '0;
        else begin
          m_wr_en = 1; m_wr_data = stk[stk.size()-1];
        end
      end
    end
  endtask

  task automatic drive(bit j, bit r, logic [31:0] pc, bit c, bit rs);
    @(negedge clk);
    reset        = rs;
    bus.jal      = j;
    bus.jr_ra    = r;
    bus.pc_plus4 = pc;
    bus.flag_clr = c;
    @(posedge clk);
    model_step(j, r, pc, c, rs);
    #2;
  endtask

  task automatic idle();      drive(0, 0, '0, 0, 0); endtask
  task automatic push(logic [31:0] pc); drive(1, 0, pc, 0, 0); endtask
  task automatic pop();       drive(0, 1, '0, 0, 0); endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      check("count",      32'(bus.count), 32'(stk.size()));
      check("empty",      32'(bus.empty), 32'(stk.size() == 0));
      check("full",       32'(bus.full),  32'(stk.size() == DEPTH));
      check("ra_top",     bus.ra_top, (stk.size() == 0) ? 32'h0 : stk[stk.size()-1]);
      check("ra_wr_en",   32'(bus.ra_wr_en), 32'(m_wr_en));
      check("ra_wr_data", bus.ra_wr_data, m_wr_data);
      check("overflow",   32'(bus.overflow), 32'(m_ovf));
      check("underflow",  32'(bus.underflow), 32'(m_udf));
    end
  end

  initial begin
    bus.jal = 0; bus.jr_ra = 0; bus.pc_plus4 = '0; bus.flag_clr = 0;
    drive(0, 0, '0, 0, 1);
    chk_en = 1'b1;
    repeat (3) idle();
    check("lit_rst_count", 32'(bus.count), 32'd0);
    check("lit_rst_empty", 32'(bus.empty), 32'd1);
    check("lit_rst_wr_data", bus.ra_wr_data, 32'h0);
    check("lit_rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);

    push(32'h10); check("lit_push1_data", bus.ra_wr_data, 32'h10);
    push(32'h20); check("lit_push2_data", bus.ra_wr_data, 32'h20);
    push(32'h30); check("lit_push3_data", bus.ra_wr_data, 32'h30);
    check("lit_push_count", 32'(bus.count), 32'd3);
    check("lit_push_top", bus.ra_top, 32'h30);
    pop(); check("lit_pop1_data", bus.ra_wr_data, 32'h20);
    pop(); check("lit_pop2_data", bus.ra_wr_data, 32'h10);
    check("lit_pop2_count", 32'(bus.count), 32'd1);
    pop(); check("lit_pop3_data", bus.ra_wr_data, 32'h0);
    check("lit_pop3_wr_en", 32'(bus.ra_wr_en), 32'd0);
    pop(); check("lit_uflow", 32'(bus.underflow), 32'd1);
    check("lit_uflow_wr_en", 32'(bus.ra_wr_en), 32'd0);

    drive(0, 0, '0, 1, 0);
    for (int i = 1; i <= 9; i++) push(32'(i * 32'h100));
    check("lit_ovf_full", 32'(bus.full), 32'd1);
    check("lit_ovf_flag", 32'(bus.overflow), 32'd1);
    check("lit_ovf_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 7; i++) begin
      pop();
      check("lit_wrap_pop", bus.ra_wr_data, 32'h800 - 32'(i) * 32'h100);
    end
    pop(); check("lit_wrap_empty", 32'(bus.empty), 32'd1);
    pop(); check("lit_wrap_uflow", 32'(bus.underflow), 32'd1);

    drive(0, 0, '0, 1, 0);
    push(32'h11); push(32'h44);
    drive(1, 1, 32'h88, 0, 0);
    check("lit_repl_count", 32'(bus.count), 32'd2);
    check("lit_repl_top", bus.ra_top, 32'h88);
    check("lit_repl_data", bus.ra_wr_data, 32'h88);
    pop(); check("lit_repl_pop", bus.ra_wr_data, 32'h11);
    pop();
    drive(1, 1, 32'h99, 0, 0);
    check("lit_both_empty_count", 32'(bus.count), 32'd1);
    check("lit_both_empty_uflow", 32'(bus.underflow), 32'd0);

    for (int i = 0; i < 9; i++) push(32'h1000 + 32'(i));
    check("lit_pre_rst_ovf", 32'(bus.overflow), 32'd1);
    drive(1, 0, 32'hdead, 1, 1);
    check("lit_rst_jal_count", 32'(bus.count), 32'd0);
    check("lit_rst_jal_ovf", 32'(bus.overflow), 32'd0);
    check("lit_rst_jal_wr_en", 32'(bus.ra_wr_en), 32'd0);
    drive(0, 1, '0, 1, 0);
    check("lit_clr_vs_uflow", 32'(bus.underflow), 32'd1);

    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      drive(sel < 45 || (sel >= 80 && sel < 90),
            sel >= 45 && sel < 90,
            $urandom,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
